lfsr_rng_scheduler: RTL and testbench
=====================================

// Module: lfsr_rng_scheduler
// PURPOSE
//  Owns one LFSR pseudo-random generator instance and shares it among N requesters.
//  Sequences configuration: seed/tap load, LFSR reset pulse, warm-up discard.
//  Then grants LFSR words to requesters, one grant per cycle, round-robin.
//  Sits between the LFSR datapath (clk, sync rst, tap, seed -> value) and its consumers.
// PARAMETERS
//  SIZE          8      LFSR width; must be >= 3
//  N_REQ         4      number of requesters; must be >= 2
//  WARMUP        4      LFSR steps discarded after every (re)seed; 0 = none
//  DEFAULT_TAP   8'h1D  tap applied after reset, before any cfg_load
//  DEFAULT_SEED  8'h01  seed applied after reset, before any cfg_load
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      asynchronous reset, active-high
//  cfg_load    in   1      1-cycle strobe: capture cfg_tap/cfg_seed and reseed
//  cfg_tap     in   SIZE   new tap mask, sampled when cfg_load=1
//  cfg_seed    in   SIZE   new seed, sampled when cfg_load=1
//  cfg_ready   out  1      1 only in RUN; generator usable
//  lfsr_rst    out  1      synchronous reset to the LFSR instance (loads lfsr_seed)
//  lfsr_tap    out  SIZE   registered tap driven to the LFSR instance
//  lfsr_seed   out  SIZE   registered seed driven to the LFSR instance
//  lfsr_value  in   SIZE   current LFSR state; advances every clk when lfsr_rst=0
//  req         in   N_REQ  level requests, one bit per requester
//  gnt         out  N_REQ  one-hot grant, 1-cycle pulse
//  rnd_data    out  SIZE   random word for the granted requester
//  rnd_valid   out  1      1 when gnt is non-zero
// BEHAVIOUR
//  Reset (rst=1, async): state=SEED; lfsr_tap=DEFAULT_TAP; lfsr_seed=DEFAULT_SEED.
//   lfsr_rst=1; gnt=0; rnd_valid=0; rnd_data=0; cfg_ready=0.
//   Warm-up counter=0; round-robin pointer=0 (requester 0 has highest priority).
//  FSM: SEED -> WARM -> RUN. Any cfg_load -> SEED.
//  SEED: lasts exactly 1 cycle with lfsr_rst=1.
//   Next state is WARM, or RUN directly if WARMUP=0.
//   Warm-up counter cleared.
//  WARM: lfsr_rst=0. Counter increments each cycle.
//   Leaves for RUN after exactly WARMUP cycles.
//   Counter width is clog2(WARMUP+1).
//  RUN: cfg_ready=1. Each cycle with req!=0, pick the first set bit at or after the pointer.
//   Search wraps from N_REQ-1 to 0.
//   Next cycle: gnt=onehot(winner), rnd_data=lfsr_value sampled at the arbitration edge, rnd_valid=1.
//   Pointer becomes (winner+1) mod N_REQ. Pointer is unchanged when req=0.
//   Latency req->gnt is 1 cycle. No grants outside RUN; gnt=0 and rnd_valid=0 there.
//   A requester holding req gets at most one grant per N_REQ grants while others request.
//   It must drop req the cycle after gnt if it wants only one word.
//   rnd_data holds its last value when rnd_valid=0.
//  cfg_load (any state): on that edge, lfsr_tap<=cfg_tap and lfsr_seed<=cfg_seed.
//   state<=SEED, counter cleared. Any grant that would issue that cycle is suppressed.
//   Pointer is preserved. cfg_load in SEED/WARM restarts the sequence (warm-up restarts from 0).
//  lfsr_rst is asserted in the cycle after cfg_load, so the LFSR sees the new tap and seed together.
//  Tap sanitising (all-0/all-1) is done by the LFSR itself; values pass through unmodified.
//  rst mid-grant: all outputs return to reset values immediately (async); no partial grant survives.
// TESTING
//  T1 reset, no cfg (SIZE=8,WARMUP=4): release rst.
//   -> lfsr_rst=1 exactly 1 cycle; cfg_ready rises 5 cycles after release.
//   -> lfsr_tap=8'h1D, lfsr_seed=8'h01.
//  T2 single requester: RUN, req=4'b0100 for one cycle.
//   -> next cycle gnt=4'b0100, rnd_valid=1, rnd_data = lfsr_value at the request edge.
//  T3 round-robin: req=4'b1111 held 8 cycles.
//   -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
//   -> rnd_data equal to 8 consecutive LFSR states.
//  T4 wrap/skip: pointer=3, req=4'b0101 -> gnt=0001, then gnt=0100, then gnt=0001.
//  T5 cfg during traffic: cfg_load with tap=8'hB8, seed=8'h5A while req=4'b1111.
//   -> no gnt that cycle; lfsr_rst=1 next cycle with lfsr_seed=8'h5A.
//   -> 4 WARM cycles with gnt=0, then grants resume at the preserved pointer.
//  T6 async reset mid-RUN: rst pulse between edges.
//   -> gnt=0, rnd_valid=0, cfg_ready=0 immediately; full reseed sequence repeats (as T1).

Source files
------------

// File: rtl/lfsr_rng_scheduler.sv
// Shares one external LFSR among N_REQ requesters. It runs the seed and warm-up sequence,
// then hands out one random word per cycle using round-robin arbitration.
module lfsr_rng_scheduler #(
  parameter int unsigned     SIZE         = 8,
  parameter int unsigned     N_REQ        = 4,
  parameter int unsigned     WARMUP       = 4,
  parameter logic [SIZE-1:0] DEFAULT_TAP  = 8'h1D,
  parameter logic [SIZE-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [SIZE-1:0]  cfg_tap,
  input  logic [SIZE-1:0]  cfg_seed,
  output logic             cfg_ready,
  output logic             lfsr_rst,
  output logic [SIZE-1:0]  lfsr_tap,
  output logic [SIZE-1:0]  lfsr_seed,
  input  logic [SIZE-1:0]  lfsr_value,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SIZE-1:0]  rnd_data,
  output logic             rnd_valid
);

  // state     | meaning
  // ST_SEED   | LFSR held in sync reset for one cycle, loading lfsr_seed
  // ST_WARM   | LFSR free-running, outputs discarded for WARMUP cycles
  // ST_RUN    | generator usable, grants issued round-robin
  localparam logic [1:0] ST_SEED = 2'd0;
  localparam logic [1:0] ST_WARM = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  logic [1:0]    state;
  logic [CW-1:0] warm_cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr_next;
  logic          hit;

  assign lfsr_rst  = (state == ST_SEED);
  assign cfg_ready = (state == ST_RUN);

  // The search starts at ptr and wraps around, so the most recent winner has the lowest priority.
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      idx = PW'((int'(ptr) + i) % int'(N_REQ));
      if (!hit && req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  assign ptr_next = (win == PTR_LAST) ? '0 : win + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SEED;
      warm_cnt  <= '0;
      lfsr_tap  <= DEFAULT_TAP;
      lfsr_seed <= DEFAULT_SEED;
    end else if (cfg_load) begin
      lfsr_tap  <= cfg_tap;
      lfsr_seed <= cfg_seed;
      state     <= ST_SEED;
      warm_cnt  <= '0;
    end else begin
      case (state)
        ST_SEED: begin
          warm_cnt <= '0;
          state    <= (WARMUP == 0) ? ST_RUN : ST_WARM;
        end
        ST_WARM: begin
          warm_cnt <= warm_cnt + CW'(1);
          if (warm_cnt == WARM_LAST) state <= ST_RUN;
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_SEED;
      endcase
    end
  end

  // A cfg_load cancels the grant for that cycle. The pointer is kept across reseeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      ptr       <= '0;
    end else if (state == ST_RUN && hit && !cfg_load) begin
      gnt       <= N_REQ'(1) << win;
      rnd_valid <= 1'b1;
      rnd_data  <= lfsr_value;
      ptr       <= ptr_next;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_rng_scheduler.sv
// Bench for lfsr_rng_scheduler. A Galois LFSR stands in for the external generator.
// A transaction-level model tracks cycles since reseed, the round-robin pointer and the expected outputs.
module tb_lfsr_rng_scheduler;
  localparam int SIZE   = 8;
  localparam int N      = 4;
  localparam int WARMUP = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_load;
  logic [SIZE-1:0] cfg_tap, cfg_seed;
  logic            cfg_ready, lfsr_rst;
  logic [SIZE-1:0] lfsr_tap, lfsr_seed, lfsr_value, rnd_data;
  logic [N-1:0]    req, gnt;
  logic            rnd_valid;

  int n_chk, n_err;
  int since, ptr;
  logic [SIZE-1:0] m_tap, m_seed, m_data;
  logic [N-1:0]    m_gnt;
  logic            m_valid;
  logic [SIZE-1:0] prev_data;
  int cyc;

  always #5 clk = ~clk;

  lfsr_rng_scheduler #(
    .SIZE(SIZE), .N_REQ(N), .WARMUP(WARMUP),
    .DEFAULT_TAP(8'h1D), .DEFAULT_SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_tap(cfg_tap), .cfg_seed(cfg_seed),
    .cfg_ready(cfg_ready), .lfsr_rst(lfsr_rst), .lfsr_tap(lfsr_tap), .lfsr_seed(lfsr_seed),
    .lfsr_value(lfsr_value), .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid)
  );

  function automatic logic [SIZE-1:0] lfsr_next(input logic [SIZE-1:0] v, input logic [SIZE-1:0] t);
    return v[0] ? ((v >> 1) ^ t) : (v >> 1);
  endfunction

  always @(posedge clk) begin
    if (lfsr_rst) lfsr_value <= lfsr_seed;
    else          lfsr_value <= lfsr_next(lfsr_value, lfsr_tap);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    since = 0; ptr = 0;
    m_tap = 8'h1D; m_seed = 8'h01; m_data = '0;
    m_gnt = '0; m_valid = 1'b0;
  endtask

  task automatic check_outputs();
    chk_eq("cfg_ready", 32'(cfg_ready), 32'(since > WARMUP));
    chk_eq("lfsr_rst",  32'(lfsr_rst),  32'(since == 0));
    chk_eq("lfsr_tap",  32'(lfsr_tap),  32'(m_tap));
    chk_eq("lfsr_seed", 32'(lfsr_seed), 32'(m_seed));
    chk_eq("gnt",       32'(gnt),       32'(m_gnt));
    chk_eq("rnd_valid", 32'(rnd_valid), 32'(m_valid));
    chk_eq("rnd_data",  32'(rnd_data),  32'(m_data));
  endtask

  // Sample the inputs before the edge, advance the model over the edge, then check the outputs.
  task automatic step();
    logic [SIZE-1:0] p_lv, p_tap, p_seed;
    logic [N-1:0]    p_req;
    logic            p_cfg;
    int              w, i;
    bit              found;
    p_lv = lfsr_value; p_req = req; p_cfg = cfg_load; p_tap = cfg_tap; p_seed = cfg_seed;
    @(posedge clk);
    if (p_cfg) begin
      m_tap = p_tap; m_seed = p_seed; since = 0;
      m_gnt = '0; m_valid = 1'b0;
    end else begin
      found = 1'b0; w = 0;
      if (since > WARMUP) begin
        for (int k = 0; k < N; k++) begin
          i = (ptr + k) % N;
          if (!found && p_req[i]) begin found = 1'b1; w = i; end
        end
      end
      if (found) begin
        m_gnt = N'(1) << w; m_valid = 1'b1; m_data = p_lv; ptr = (w + 1) % N;
      end else begin
        m_gnt = '0; m_valid = 1'b0;
      end
      if (since < 100000) since++;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1; cfg_load = 1'b0; cfg_tap = '0; cfg_seed = '0; req = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    #3 rst = 1'b0;

    // Bring-up with no configuration: cfg_ready should rise five cycles after reset release.
    cyc = 0;
    while (!cfg_ready && cyc < 20) begin step(); cyc++; end
    chk_eq("t1_ready_lat", 32'(cyc), 32'd5);
    chk_eq("t1_tap", 32'(lfsr_tap), 32'h1D);
    chk_eq("t1_seed", 32'(lfsr_seed), 32'h01);

    // All four requesters held: grants rotate, and the data follows consecutive LFSR states.
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      chk_eq("t3_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      if (k > 0) chk_eq("t3_consec", 32'(rnd_data), 32'(lfsr_next(prev_data, 8'h1D)));
      prev_data = rnd_data;
    end
    req = '0; step();

    // A single one-cycle request.
    req = 4'b0100; step();
    chk_eq("t2_gnt", 32'(gnt), 32'h4);
    chk_eq("t2_valid", 32'(rnd_valid), 32'h1);
    req = '0; step();
    chk_eq("t2_gnt_off", 32'(gnt), 32'h0);

    // Pointer is now 3, so the search wraps to 0 and skips the idle requesters.
    req = 4'b0101;
    step(); chk_eq("t4_gnt0", 32'(gnt), 32'h1);
    step(); chk_eq("t4_gnt1", 32'(gnt), 32'h4);
    step(); chk_eq("t4_gnt2", 32'(gnt), 32'h1);
    req = '0; step();

    // cfg_load arrives while traffic is running.
    req = 4'b1111; step();
    cfg_load = 1'b1; cfg_tap = 8'hB8; cfg_seed = 8'h5A; step();
    chk_eq("t5_gnt_supp", 32'(gnt), 32'h0);
    chk_eq("t5_lfsr_rst", 32'(lfsr_rst), 32'h1);
    chk_eq("t5_seed", 32'(lfsr_seed), 32'h5A);
    cfg_load = 1'b0;
    for (int k = 0; k < 5; k++) begin step(); chk_eq("t5_warm_gnt", 32'(gnt), 32'h0); end
    step(); chk_eq("t5_resume", 32'(gnt), 32'h4);

    // Random traffic, with an occasional reseed.
    for (int k = 0; k < 3000; k++) begin
      req      = N'($urandom);
      cfg_load = ($urandom_range(0, 63) == 0);
      cfg_tap  = SIZE'($urandom);
      cfg_seed = SIZE'($urandom_range(1, 255));
      step();
    end
    cfg_load = 1'b0;

    // Asynchronous reset between clock edges while RUN is active.
    req = 4'b1111;
    cyc = 0;
    while (!cfg_ready && cyc < 20) begin step(); cyc++; end
    chk_eq("t6_pre_ready", 32'(cfg_ready), 32'h1);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk_eq("t6_gnt", 32'(gnt), 32'h0);
    chk_eq("t6_valid", 32'(rnd_valid), 32'h0);
    chk_eq("t6_ready", 32'(cfg_ready), 32'h0);
    chk_eq("t6_lfsr_rst", 32'(lfsr_rst), 32'h1);
    chk_eq("t6_data", 32'(rnd_data), 32'h0);
    chk_eq("t6_tap", 32'(lfsr_tap), 32'h1D);
    chk_eq("t6_seed", 32'(lfsr_seed), 32'h01);
    model_reset();
    req = '0;
    #1 rst = 1'b0;
    cyc = 0;
    while (!cfg_ready && cyc < 20) begin step(); cyc++; end
    chk_eq("t6_ready_lat", 32'(cyc), 32'd5);
    req = 4'b0010; step();
    chk_eq("t6_gnt_after", 32'(gnt), 32'h2);
    req = '0; step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
